// File: rtl/led_mode_sequencer_pkg.sv
// rtl/led_mode_sequencer_pkg.sv - mode encodings, initial patterns and PWM width for the LED sequencer
package led_seq_pkg;

    localparam logic [1:0] MODE_CHASE_L = 2'd0;
    localparam logic [1:0] MODE_CHASE_R = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BAR     = 2'd3;

    localparam int PWM_CNT_W = 8;
    localparam int MAX_LED   = 32;

    // Pattern loaded on entry to a mode (active-high, bit 0 is the first LED)
    function automatic logic [MAX_LED-1:0] init_pat(input logic [1:0] mode, input int n_led);
        logic [MAX_LED-1:0] v;
        v = '0;
        case (mode)
            MODE_CHASE_L: v = MAX_LED'(1);
            MODE_CHASE_R: v = MAX_LED'(1) << (n_led - 1);
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/led_mode_sequencer_if.sv
// rtl/led_mode_sequencer_if.sv - push-button input and LED/mode/step outputs of the sequencer
interface led_mode_sequencer_if #(
    parameter int N_LED = 6
);
    logic             PSW;
    logic [N_LED-1:0] LED;
    logic [1:0]       MODE;
    logic             STEP;

    modport master (output PSW, input LED, MODE, STEP);
    modport slave  (input PSW, output LED, MODE, STEP);
endinterface

// File: rtl/led_mode_sequencer_psw_debounce.sv
// rtl/led_mode_sequencer_psw_debounce.sv - PSW synchronizer, debounce counter and press pulse
module psw_debounce #(
    parameter int DEBOUNCE_CYC = 270_000
) (
    input  logic CLK,
    input  logic ARST_N,
    input  logic i_psw,
    output logic o_press
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic [DB_W-1:0] r_cnt;
    logic            r_press;

    // Counter only runs while the synced level disagrees with the accepted level
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_db    <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_psw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                r_db    <= r_sync2;
                r_cnt   <= '0;
                r_press <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - LED bank mode FSM, step prescaler and pattern register; optional PWM dimming under LED_SEQ_PWM_EN
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int STEP_DIV     = 4_000_000,
    parameter int DEBOUNCE_CYC = 270_000,
    parameter int N_LED        = 6,
    parameter int PWM_DUTY     = 128
) (
    input  logic                 CLK,
    input  logic                 ARST_N,
    led_mode_sequencer_if.slave  seq_bus
);
    localparam int DIV_W = $clog2(STEP_DIV);

    if (STEP_DIV < 2 || DEBOUNCE_CYC < 2 || N_LED < 2 || N_LED > MAX_LED ||
        PWM_DUTY < 0 || PWM_DUTY > 256) begin : g_bad_param
        $error("led_mode_sequencer: parameter out of range");
    end

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_mode;
    logic [N_LED-1:0] r_pat;
    logic             w_press;
    logic             w_tick;
    logic [1:0]       w_next_mode;
    logic [N_LED-1:0] w_init;
    logic [N_LED-1:0] w_step_pat;

    psw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_psw_debounce (
        .CLK     (CLK),
        .ARST_N  (ARST_N),
        .i_psw   (seq_bus.PSW),
        .o_press (w_press)
    );

    assign w_tick      = (r_div == DIV_W'(STEP_DIV - 1));
    assign w_next_mode = r_mode + 2'd1;
    assign w_init      = N_LED'(init_pat(w_next_mode, N_LED));

    always_comb begin
        w_step_pat = r_pat;
        case (r_mode)
            MODE_CHASE_L: w_step_pat = {r_pat[N_LED-2:0], r_pat[N_LED-1]};
            MODE_CHASE_R: w_step_pat = {r_pat[0], r_pat[N_LED-1:1]};
            MODE_BLINK:   w_step_pat = ~r_pat;
            default:      w_step_pat = (&r_pat) ? '0 : {r_pat[N_LED-2:0], 1'b1};
        endcase
    end

    // A press restarts the step period so the new mode always gets a full first step
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_div  <= '0;
            r_mode <= MODE_CHASE_L;
            r_pat  <= N_LED'(1);
        end else if (w_press) begin
            r_div  <= '0;
            r_mode <= w_next_mode;
            r_pat  <= w_init;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                r_pat <= w_step_pat;
            end
        end
    end

    assign seq_bus.STEP = w_tick & ~w_press;
    assign seq_bus.MODE = r_mode;

`ifdef LED_SEQ_PWM_EN
    logic [PWM_CNT_W-1:0] r_pwm_cnt;
    logic                 r_pwm_on;
    logic [N_LED-1:0]     r_led;

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_pwm_cnt <= '0;
            r_pwm_on  <= 1'b0;
            r_led     <= ~N_LED'(1);
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_CNT_W'(1);
            r_pwm_on  <= (int'(r_pwm_cnt) < PWM_DUTY);
            r_led     <= ~(r_pat & {N_LED{r_pwm_on}});
        end
    end

    assign seq_bus.LED = r_led;
`else
    assign seq_bus.LED = ~r_pat;
`endif

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - self-checking bench for led_mode_sequencer
module tb_led_mode_sequencer;
    import led_seq_pkg::*;

    localparam int STEP_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;
    localparam int N_LED        = 6;

    logic CLK    = 1'b0;
    logic ARST_N = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    led_mode_sequencer_if #(.N_LED(N_LED)) bus ();

    led_mode_sequencer #(
        .STEP_DIV     (STEP_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .N_LED        (N_LED),
        .PWM_DUTY     (64)
    ) dut (
        .CLK     (CLK),
        .ARST_N  (ARST_N),
        .seq_bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] mode;
        logic [5:0] led;
    } vec_t;

    vec_t       tbl[22];
    logic [5:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_mode(input logic [1:0] m, input int n);
        int k = 0;
        foreach (tbl[i]) begin
            if (tbl[i].mode == m && k < n) begin
                exp_q.push_back(tbl[i].led);
                k++;
            end
        end
    endtask

    task automatic step_and_check(input string name);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.STEP !== 1'b1 && n < STEP_DIV + 4);
        check({name, "_gap"}, n, STEP_DIV - 1);
        @(negedge CLK);
        if (exp_q.size() == 0) check({name, "_q_empty"}, 1, 0);
        else                   check({name, "_led"}, bus.LED, exp_q.pop_front());
    endtask

    task automatic run_mode(input logic [1:0] m, input int n, input string name);
        push_mode(m, n);
        repeat (n) step_and_check(name);
    endtask

    task automatic press(input logic [1:0] exp_mode, input logic [5:0] exp_led,
                         input bit hold, input string name);
        int         n  = 0;
        logic [1:0] m0 = bus.MODE;
        bus.PSW = 1'b0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.MODE === m0 && n < 40);
        check({name, "_latency"}, n, DEBOUNCE_CYC + 3);
        check({name, "_mode"}, bus.MODE, exp_mode);
        check({name, "_led"}, bus.LED, exp_led);
        if (!hold) bus.PSW = 1'b1;
    endtask

    task automatic release_idle();
        bus.PSW = 1'b1;
        repeat (DEBOUNCE_CYC + 4) @(negedge CLK);
    endtask

    initial begin
        tbl = '{
            '{MODE_CHASE_L, 6'b111101}, '{MODE_CHASE_L, 6'b111011}, '{MODE_CHASE_L, 6'b110111},
            '{MODE_CHASE_L, 6'b101111}, '{MODE_CHASE_L, 6'b011111}, '{MODE_CHASE_L, 6'b111110},
            '{MODE_CHASE_R, 6'b101111}, '{MODE_CHASE_R, 6'b110111}, '{MODE_CHASE_R, 6'b111011},
            '{MODE_CHASE_R, 6'b111101}, '{MODE_CHASE_R, 6'b111110}, '{MODE_CHASE_R, 6'b011111},
            '{MODE_BLINK,   6'b000000}, '{MODE_BLINK,   6'b111111}, '{MODE_BLINK,   6'b000000},
            '{MODE_BAR,     6'b111110}, '{MODE_BAR,     6'b111100}, '{MODE_BAR,     6'b111000},
            '{MODE_BAR,     6'b110000}, '{MODE_BAR,     6'b100000}, '{MODE_BAR,     6'b000000},
            '{MODE_BAR,     6'b111111}
        };
        bus.PSW = 1'b1;
        ARST_N  = 1'b0;
        #12;
        check("reset_led", bus.LED, 6'b111110);
        check("reset_mode", bus.MODE, 2'd0);
        check("reset_step", bus.STEP, 1'b0);
        @(negedge CLK);
        ARST_N = 1'b1;

`ifdef LED_SEQ_PWM_EN
        begin
            int lit = 0;
            int bad = 0;
            repeat (10) @(negedge CLK);
            repeat (256) begin
                @(negedge CLK);
                if (bus.LED != 6'b111111) lit++;
                if ($countones(~bus.LED) > 1) bad++;
            end
            check("pwm_lit_cycles", lit, 64);
            check("pwm_unlit_bits", bad, 0);
        end
`else
        run_mode(MODE_CHASE_L, 6, "chase_l");

        bus.PSW = 1'b0;
        repeat (5) @(negedge CLK);
        release_idle();
        check("bounce_mode", bus.MODE, 2'd0);

        press(MODE_CHASE_R, 6'b011111, 1'b1, "press1");
        run_mode(MODE_CHASE_R, 6, "chase_r");
        check("hold_no_press", bus.MODE, 2'd1);
        release_idle();

        press(MODE_BLINK, 6'b111111, 1'b0, "press2");
        run_mode(MODE_BLINK, 3, "blink");
        release_idle();
        press(MODE_BAR, 6'b111111, 1'b0, "press3");
        run_mode(MODE_BAR, 7, "bar");
        release_idle();
        press(MODE_CHASE_L, 6'b111110, 1'b0, "press4");
        run_mode(MODE_CHASE_L, 3, "chase_l2");

        // Drop PSW so the press pulse lands in a cycle where the prescaler is at its limit
        @(negedge CLK);
        bus.PSW = 1'b0;
        for (int n = 1; n <= DEBOUNCE_CYC + 3; n++) begin
            @(negedge CLK);
            if (n == DEBOUNCE_CYC + 2) check("collide_step", bus.STEP, 1'b0);
        end
        check("collide_mode", bus.MODE, 2'd1);
        check("collide_led", bus.LED, 6'b011111);
        bus.PSW = 1'b1;
        run_mode(MODE_CHASE_R, 1, "after_collide");

        release_idle();
        press(MODE_BLINK, 6'b111111, 1'b0, "press6");
        release_idle();
        press(MODE_BAR, 6'b111111, 1'b0, "press7");
        run_mode(MODE_BAR, 2, "bar2");
        @(posedge CLK);
        #3;
        ARST_N = 1'b0;
        #1;
        check("async_rst_led", bus.LED, 6'b111110);
        check("async_rst_mode", bus.MODE, 2'd0);
        check("async_rst_step", bus.STEP, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
